fact_seq_mul: RTL and testbench

//  Sequential unsigned WIDTH x WIDTH -> 2*WIDTH shift-add multiplier.

---
 rtl/fact_pkg.sv | 18 +
 rtl/fact_mul_step.sv | 18 +
 rtl/fact_seq_mul.sv | 111 +++++++++++
 tb/tb_fact_seq_mul.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/fact_pkg.sv
// Shared constants for the factorial datapath: operand/result widths and
// the multiplier FSM state encodings used by the controller and decoder.
package fact_pkg;

  localparam int FACT_W     = 64;
  localparam int FACT_RES_W = 128;

  localparam logic [1:0] MUL_IDLE = 2'd0;
  localparam logic [1:0] MUL_EXEC = 2'd1;
  localparam logic [1:0] MUL_DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = MUL_IDLE,
    ST_EXEC = MUL_EXEC,
    ST_DONE = MUL_DONE
  } mul_state_e;

endpackage

// File: rtl/fact_mul_step.sv
// One shift-add iteration: if the accumulator LSB is set, add the multiplicand
// into the high half (carry lands in the extra top bit), then shift right by one.
module fact_mul_step #(
  parameter int WIDTH = 64
) (
  input  logic [2*WIDTH:0]  acc,
  input  logic [WIDTH-1:0]  mcand,
  output logic [2*WIDTH:0]  acc_next
);

  logic [WIDTH:0] hi_sum;

  // The top accumulator bit is always clear between steps, so {carry, hi}
  // plus a WIDTH-bit addend never overflows WIDTH+1 bits.
  assign hi_sum   = acc[2*WIDTH:WIDTH] + {1'b0, mcand & {WIDTH{acc[0]}}};
  assign acc_next = {1'b0, hi_sum, acc[WIDTH-1:1]};

endmodule

// File: rtl/fact_seq_mul.sv
// Sequential unsigned WIDTH x WIDTH -> 2*WIDTH shift-add multiplier, one bit per clock.
// Optional MUL_EARLY_EXIT_EN finishes as soon as the remaining multiplier bits are zero.
module fact_seq_mul
  import fact_pkg::*;
#(
  parameter int WIDTH = FACT_W
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               op_start,
  input  logic               op_clear,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic [2*WIDTH-1:0] result,
  output logic               op_done
);

  localparam int CNT_W = $clog2(WIDTH);

  mul_state_e         state, state_next;
  logic [2*WIDTH:0]   acc, acc_next;
  logic [WIDTH-1:0]   mcand;
  logic [CNT_W-1:0]   cnt;
  logic               exec_last;
  logic [2*WIDTH-1:0] exec_result;

  fact_mul_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc),
    .mcand    (mcand),
    .acc_next (acc_next)
  );

`ifdef MUL_EARLY_EXIT_EN
  logic [WIDTH-1:0]  pending_mask;
  logic [CNT_W:0]    align_sh;
  logic [2*WIDTH:0]  aligned;
  logic              rest_zero;

  // Once the unprocessed multiplier bits are all zero, the remaining steps
  // would only shift, so do them in one barrel shift.
  always_comb begin
    pending_mask = {WIDTH{1'b1}} >> cnt;
    align_sh     = (CNT_W+1)'(WIDTH) - {1'b0, cnt};
    aligned      = acc >> align_sh;
    rest_zero    = ~|(acc[WIDTH-1:0] & pending_mask);
  end
`endif

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next  = state;
    exec_last   = (cnt == CNT_W'(WIDTH - 1));
    exec_result = acc_next[2*WIDTH-1:0];
`ifdef MUL_EARLY_EXIT_EN
    if (rest_zero) begin
      exec_last   = 1'b1;
      exec_result = aligned[2*WIDTH-1:0];
    end
`endif
    if (op_clear) begin
      state_next = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: if (op_start)  state_next = ST_EXEC;
        ST_EXEC: if (exec_last) state_next = ST_DONE;
        ST_DONE: state_next = ST_DONE;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // NOTE: the datapath registers are reset too, so a reset mid-multiply
  // leaves no stale partial product behind.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      result <= '0;
      acc    <= '0;
      mcand  <= '0;
      cnt    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      state <= state_next;
      if (op_clear) begin
        cnt <= '0;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (op_start) begin
              mcand <= multiplicand;
              acc   <= {1'b0, {WIDTH{1'b0}}, multiplier};
              cnt   <= '0;
            end
          end
          ST_EXEC: begin
            acc <= acc_next;
            cnt <= cnt + CNT_W'(1);
            if (exec_last) result <= exec_result;
          end
          default: ;
        endcase
      end
    end
  end

  // Result survives a clear so the controller can still read the last product.
  assign op_done = (state == ST_DONE);

endmodule

// File: tb/tb_fact_seq_mul.sv
// Directed bench for fact_seq_mul: table of operand/product/latency vectors
// plus hand-written clear, simultaneous start/clear and async-reset sequences.
module tb_fact_seq_mul;

  logic         clk;
  logic         reset_n;
  logic         op_start;
  logic         op_clear;
  logic [63:0]  multiplicand;
  logic [63:0]  multiplier;
  logic [127:0] result;
  logic         op_done;

  int tests = 0;
  int fails = 0;

  fact_seq_mul #(.WIDTH(64)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .op_start     (op_start),
    .op_clear     (op_clear),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .result       (result),
    .op_done      (op_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [63:0]  a;
    logic [63:0]  b;
    logic [127:0] prod;
    int           lat;
    string        name;
  } vec_t;

`ifdef MUL_EARLY_EXIT_EN
  localparam int CLR_EDGE = 2;
`else
  localparam int CLR_EDGE = 10;
`endif

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected latency: fixed 64 edges, or 2 + highest set bit index (capped) with early exit.
  function automatic int exp_lat(input logic [63:0] b);
`ifdef MUL_EARLY_EXIT_EN
    int h;
    h = -1;
    for (int i = 0; i < 64; i++) if (b[i]) h = i;
    if (h < 0) return 1;
    return (h + 2 > 64) ? 64 : h + 2;
`else
    return (b === 64'hx) ? 0 : 64;
`endif
  endfunction

  task automatic run_vec(input vec_t v);
    int n;
    multiplicand = v.a;
    multiplier   = v.b;
    op_start     = 1'b1;
    @(posedge clk); #1;
    multiplicand = ~v.a;
    multiplier   = ~v.b;
    n = 0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      if (op_done) begin
        n = k;
        break;
      end
    end
    check({v.name, " latency"}, 128'(n), 128'(v.lat));
    check({v.name, " result"}, result, v.prod);
    repeat (3) @(posedge clk);
    #1;
    check({v.name, " done held with start high"}, 128'(op_done), 128'd1);
    check({v.name, " result held in DONE"}, result, v.prod);
    op_start = 1'b0;
    op_clear = 1'b1;
    @(posedge clk); #1;
    op_clear = 1'b0;
    check({v.name, " done cleared"}, 128'(op_done), 128'd0);
    check({v.name, " result kept after clear"}, result, v.prod);
  endtask

  vec_t vecs[8];
  vec_t v_post;
  logic [127:0] last_prod;
  int saw_done;

  initial begin
    vecs[0] = '{64'd5, 64'd4, 128'd20, 0, "5x4"};
    vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, 0, "max x max"};
    vecs[2] = '{64'd7, 64'd0, 128'd0, 0, "7x0"};
    vecs[3] = '{64'd0, 64'd9, 128'd0, 0, "0x9"};
    vecs[4] = '{64'd12345, 64'd6789, 128'd83810205, 0, "12345x6789"};
    vecs[5] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF, 0, "max x 1"};
    vecs[6] = '{64'd1, 64'h8000_0000_0000_0000, 128'h0000_0000_0000_0000_8000_0000_0000_0000, 0, "1 x msb"};
    vecs[7] = '{64'd3, 64'd2, 128'd6, 0, "3x2"};
    for (int i = 0; i < 8; i++) vecs[i].lat = exp_lat(vecs[i].b);

    reset_n      = 1'b0;
    op_start     = 1'b0;
    op_clear     = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    #1;
    check("reset result", result, 128'd0);
    check("reset op_done", 128'(op_done), 128'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);
    last_prod = vecs[7].prod;

    // Clear mid-EXEC with start still high: abort, no re-acceptance while clear holds.
    multiplicand = 64'd3;
    multiplier   = 64'd6;
    op_start     = 1'b1;
    @(posedge clk); #1;
    repeat (CLR_EDGE - 1) @(posedge clk);
    #1 op_clear = 1'b1;
    saw_done = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (op_done) saw_done = 1;
    end
    check("clear+start: no done", 128'(op_done), 128'd0);
    op_clear = 1'b0;
    op_start = 1'b0;
    repeat (70) begin
      @(posedge clk); #1;
      if (op_done) saw_done = 1;
    end
    check("aborted run never done", 128'(saw_done), 128'd0);
    check("aborted run result unchanged", result, last_prod);

    // Asynchronous reset mid-EXEC, then a fresh multiply.
    multiplicand = 64'd5;
    multiplier   = 64'd4;
    op_start     = 1'b1;
    @(posedge clk); #1;
    op_start = 1'b0;
    repeat (1) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check("async reset result", result, 128'd0);
    check("async reset op_done", 128'(op_done), 128'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    v_post = '{64'd2, 64'd3, 128'd6, 0, "2x3 after reset"};
    v_post.lat = exp_lat(v_post.b);
    run_vec(v_post);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
